// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory bridge.
package dmem_pkg;

    localparam int unsigned ADDR_W_DEF = 17;
    localparam int unsigned SIZE_W     = 2;

    localparam logic [SIZE_W-1:0] SZ_B = 2'd0;
    localparam logic [SIZE_W-1:0] SZ_H = 2'd1;
    localparam logic [SIZE_W-1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Half on an odd byte, or word (size 3 included) off a word boundary.
    function automatic logic misaligned(input logic [SIZE_W-1:0] size, input logic [1:0] off);
        logic mis;
        case (size)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = off[0];
            default: mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_bridge_if.sv
// Load/store-unit request and response handshakes of the data-memory bridge.
interface dmem_bridge_if;
    import dmem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [SIZE_W-1:0] req_size;
    logic              req_unsigned;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_load_align.sv
// Selects the addressed byte/half of a RAM word and sign- or zero-extends it.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0]       rdata,
    input  logic [1:0]        off,
    input  logic [SIZE_W-1:0] size,
    input  logic              is_unsigned,
    output logic [31:0]       data_c
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_v = 8'(rdata >> {off, 3'b000});
    assign half_v = 16'(rdata >> {off[1], 4'b0000});

    always_comb begin
        data_c = rdata;
        case (size)
            SZ_B:    data_c = is_unsigned ? 32'(byte_v) : {{24{byte_v[7]}}, byte_v};
            SZ_H:    data_c = is_unsigned ? 32'(half_v) : {{16{half_v[15]}}, half_v};
            default: data_c = rdata;
        endcase
    end

endmodule

// File: rtl/dmem_bridge.sv
// LSU-to-block-RAM bridge: one request at a time, registered response.
// DMEM_MISALIGN_TRAP_EN: misaligned accesses skip the RAM and respond with rsp_err.
module dmem_bridge
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    dmem_bridge_if.slave      bus,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    state_e            state_q, state_d;
    logic              accept_c;
    logic              trap_c;
    logic [3:0]        mask_c;
    logic [31:0]       lane_c;
    logic [31:0]       align_c;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        off_q;
    logic [SIZE_W-1:0] size_q;
    logic              uns_q;
    logic              rdy_q;
    logic              vld_q;
    logic              err_q;
    logic [31:0]       rdata_q;
    logic              unused_addr;

    assign unused_addr = ^{bus.req_addr[31:ADDR_W+2]};

`ifdef DMEM_MISALIGN_TRAP_EN
    assign trap_c = misaligned(bus.req_size, bus.req_addr[1:0]);
`else
    assign trap_c = 1'b0;
`endif

    // Store byte lanes; misaligned halves/words fall onto their aligned lanes.
    always_comb begin
        mask_c = 4'b1111;
        lane_c = bus.req_wdata;
        case (bus.req_size)
            SZ_B: begin
                mask_c = 4'b0001 << bus.req_addr[1:0];
                lane_c = {4{bus.req_wdata[7:0]}};
            end
            SZ_H: begin
                mask_c = 4'b0011 << {bus.req_addr[1], 1'b0};
                lane_c = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                mask_c = 4'b1111;
                lane_c = bus.req_wdata;
            end
        endcase
    end

    // Next state and RAM drive; resetn gates acceptance so reset kills ram_we at once.
    always_comb begin
        state_d   = state_q;
        accept_c  = 1'b0;
        ram_en    = 1'b0;
        ram_we    = 4'b0000;
        ram_addr  = addr_q;
        ram_wdata = 32'h0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && resetn) begin
                    accept_c = 1'b1;
                    if (trap_c) begin
                        state_d = ST_RESP;
                    end else begin
                        ram_en   = 1'b1;
                        ram_addr = bus.req_addr[ADDR_W+1:2];
                        if (bus.req_we) begin
                            ram_we    = mask_c;
                            ram_wdata = lane_c;
                            state_d   = ST_RESP;
                        end else begin
                            state_d = ST_RD;
                        end
                    end
                end
            end
            ST_RD:   state_d = ST_RESP;
            ST_RESP: if (bus.rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    dmem_load_align u_align (
        .rdata       (ram_rdata),
        .off         (off_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .data_c      (align_c)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            rdy_q   <= 1'b1;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
            off_q   <= 2'b00;
            size_q  <= SZ_B;
            uns_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= (state_d == ST_IDLE);
            vld_q   <= (state_d == ST_RESP);
            if (ram_en) addr_q <= ram_addr;
            if (accept_c) begin
                off_q  <= bus.req_addr[1:0];
                size_q <= bus.req_size;
                uns_q  <= bus.req_unsigned;
                err_q  <= trap_c;
                if (bus.req_we || trap_c) rdata_q <= 32'h0;
            end
            if (state_q == ST_RD) rdata_q <= align_c;
        end
    end

    assign bus.req_ready = rdy_q;
    assign bus.rsp_valid = vld_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

endmodule

// File: doc/dmem_bridge.md
# dmem_bridge

Data-side bridge between the RV32 core's load/store unit and the 32-bit byte-writable block RAM. It accepts one request at a time over a valid/ready handshake and drives the RAM's enable, byte-write-enable, word address and write data. For loads it captures the RAM read word one cycle after issue, then extracts and sign- or zero-extends the addressed byte or halfword. It returns a registered response over a second valid/ready handshake.

## Interface
Parameters:
- ADDR_W, 17: RAM word-address width. The word address is req_addr[ADDR_W+1:2].

Ports:
- clk  in  1  single clock; the RAM uses the same clock.
- resetn  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  bridge can accept a request. High only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word. The value 3 is treated as word.
- req_unsigned  in  1  zero-extend loads (LBU/LHU).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  32  load result. 0 for stores.
- rsp_err  out  1  misaligned access; see Configuration.
- ram_en  out  1  RAM enable.
- ram_we  out  4  RAM byte write enables.
- ram_addr  out  ADDR_W  RAM word address.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read port. Valid one cycle after the address is presented.

## Operation
- There are three states: IDLE, RD, RESP.
- **IDLE:**
  - req_ready = 1.
  - On req_valid, the request is accepted that cycle.
  - ram_* outputs are driven combinationally from the request.
  - For a store: ram_en = 1, ram_we = byte mask, then go to RESP.
  - For a load: ram_en = 1, ram_we = 0, then go to RD.
- **RD:**
  - ram_rdata is valid this cycle.
  - The aligned, extended result is registered into rsp_rdata.
  - Go to RESP.
- **RESP:**
  - rsp_valid = 1.
  - rsp_rdata and rsp_err are held stable until rsp_ready.
  - On rsp_ready, go to IDLE.
  - No new request is accepted in the same cycle as the handshake.
- **Byte lanes for stores:**
  - Byte: ram_wdata = {4{wdata[7:0]}}, ram_we = 4'b0001 << addr[1:0].
  - Half: ram_wdata = {2{wdata[15:0]}}, ram_we = 4'b0011 << {addr[1],1'b0}.
  - Word: ram_wdata = wdata, ram_we = 4'b1111.
- **Load extraction:**
  - Byte: take ram_rdata[8*addr[1:0] +: 8].
  - Half: take ram_rdata[16*addr[1] +: 16].
  - Sign-extend unless req_unsigned.
- **Latched request fields:** addr[1:0], size and unsigned are registered at acceptance for use in RD.
- **RAM outputs outside acceptance:**
  - ram_en = 0 and ram_we = 0 in every non-accepting cycle.
  - ram_addr holds the last issued word address.
  - ram_wdata = 0.
- **RAM read data after a write:** during a write cycle the RAM's read port returns the write data, not memory contents. The bridge never samples ram_rdata after a store.

## Timing
- A request is accepted at cycle T.
- Store: the RAM writes at the clock edge ending T. rsp_valid is high from T+1. Latency 1.
- Load: the RAM address is presented in T. Data is captured in T+1. rsp_valid is high from T+2. Latency 2.
- Back-to-back throughput: at most one request per 2 cycles for stores and per 3 cycles for loads, assuming rsp_ready is held high.
- Reset (asserted asynchronously at any point, including mid-transaction):
  - State returns to IDLE.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - Latched fields = 0, ram_addr = 0.
  - An in-flight load is dropped and no response is produced.
  - ram_we is forced to 0 immediately.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined:
  - A misaligned access is a half with addr[0] = 1, or a word with addr[1:0] != 0.
  - It issues no RAM access (ram_en = 0, ram_we = 0).
  - It goes directly to RESP with rsp_err = 1 and rsp_rdata = 0. Latency 1.
- DMEM_MISALIGN_TRAP_EN undefined:
  - The low address bits below the access size are ignored, so the access is forced aligned.
  - rsp_err is tied to 0.

## Structure
- Shared package `dmem_pkg`:
  - size encodings SZ_B, SZ_H, SZ_W.
  - state enum.
  - the ADDR_W default.
- One sub-module, `dmem_load_align`. It is purely combinational: ram_rdata, addr[1:0], size and unsigned in; 32-bit extended result out.

## Test plan
- Store word 0xDEADBEEF at 0x100, then load word at 0x100 → ram_we = 4'b1111, ram_addr = 0x40; the load returns 0xDEADBEEF, rsp_err = 0, rsp_valid at T+2.
- Store byte 0x80 at 0x103, then LB and LBU at 0x103 → ram_we = 4'b1000, ram_wdata = 0x80808080; LB returns 0xFFFFFF80, LBU returns 0x00000080.
- Store half 0x1234 at 0x202, then load word at 0x200 (memory preset 0) → ram_we = 4'b1100; the load returns 0x12340000.
- Hold rsp_ready = 0 for 5 cycles after a load → rsp_valid and rsp_rdata are held stable, req_ready = 0, and no RAM access occurs.
- Store half at 0x101, with the macro defined and then undefined → defined: rsp_err = 1, no RAM write, rsp_valid at T+1. Undefined: a write to bytes [1:0] of word 0x40 with ram_we = 4'b0011, and rsp_err = 0.
- Assert resetn low during RD of a load → rsp_valid stays 0, state is IDLE after release, and req_ready = 1 on the first cycle after release.
